// File: rtl/system_bus_arbiter.sv
// Two-port system bus arbiter with an in-order read-ID FIFO that
// routes returning read words back to the requester that issued them.
module system_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIXED_PRIORITY  = 0,
  localparam int PW = $clog2(MAX_OUTSTANDING),
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [29:0]   p0_addr,
  input  logic [31:0]   p0_write_data,
  input  logic [3:0]    p0_byte_enable,
  input  logic          p0_read_req,
  input  logic          p0_write_req,
  output logic          p0_ready,
  output logic [31:0]   p0_read_data,
  output logic          p0_read_data_valid,
  input  logic [29:0]   p1_addr,
  input  logic [31:0]   p1_write_data,
  input  logic [3:0]    p1_byte_enable,
  input  logic          p1_read_req,
  input  logic          p1_write_req,
  output logic          p1_ready,
  output logic [31:0]   p1_read_data,
  output logic          p1_read_data_valid,
  input  logic          bus_ready,
  output logic [29:0]   bus_addr,
  output logic [31:0]   bus_write_data,
  output logic [3:0]    bus_byte_enable,
  output logic          bus_read_req,
  output logic          bus_write_req,
  input  logic [31:0]   bus_read_data,
  input  logic          bus_read_data_valid,
  output logic [CW-1:0] outstanding_count,
  output logic          protocol_error
);

  logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_grant_q, last_grant_d;
  logic          protocol_error_q, protocol_error_d;

  logic full, empty, pop, push, xfer, rd_ok;
  logic p0_elig, p1_elig, gnt_vld, gnt_id, head_id;

  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);
  assign pop   = bus_read_data_valid && !empty;
  // A same-cycle return frees a slot, so a full FIFO still takes a read.
  assign rd_ok = !full || bus_read_data_valid;

  assign p0_elig = p0_write_req || (p0_read_req && rd_ok);
  assign p1_elig = p1_write_req || (p1_read_req && rd_ok);

  always_comb begin
    gnt_vld = p0_elig || p1_elig;
    gnt_id  = 1'b0;
    if (p0_elig && p1_elig) begin
      gnt_id = (FIXED_PRIORITY != 0) ? 1'b1 : ~last_grant_q;
    end else if (p1_elig) begin
      gnt_id = 1'b1;
    end
  end

  always_comb begin
    bus_addr        = '0;
    bus_write_data  = '0;
    bus_byte_enable = '0;
    bus_read_req    = 1'b0;
    bus_write_req   = 1'b0;
    if (gnt_vld && gnt_id) begin
      bus_addr        = p1_addr;
      bus_write_data  = p1_write_data;
      bus_byte_enable = p1_byte_enable;
      bus_read_req    = p1_read_req;
      bus_write_req   = p1_write_req;
    end else if (gnt_vld) begin
      bus_addr        = p0_addr;
      bus_write_data  = p0_write_data;
      bus_byte_enable = p0_byte_enable;
      bus_read_req    = p0_read_req;
      bus_write_req   = p0_write_req;
    end
  end

  assign xfer = gnt_vld && bus_ready;
  assign push = xfer && bus_read_req;

  assign p0_ready = xfer && !gnt_id;
  assign p1_ready = xfer && gnt_id;

  assign head_id            = ids_q[rd_ptr_q];
  assign p0_read_data_valid = pop && !head_id;
  assign p1_read_data_valid = pop && head_id;
  assign p0_read_data       = bus_read_data;
  assign p1_read_data       = bus_read_data;

  always_comb begin
    ids_d            = ids_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    last_grant_d     = last_grant_q;
    protocol_error_d = protocol_error_q;
    if (push) begin
      ids_d[wr_ptr_q] = gnt_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (xfer) begin
      last_grant_d = gnt_id;
    end
    if (bus_read_data_valid && empty) begin
      protocol_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ids_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      last_grant_q     <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      ids_q            <= ids_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      last_grant_q     <= last_grant_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign outstanding_count = count_q;
  assign protocol_error    = protocol_error_q;

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Directed bench for system_bus_arbiter: routing, arbitration,
// FIFO full/bypass, write-only traffic, protocol error, async reset.
module tb_system_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic [29:0] p0_addr, p1_addr;
  logic [31:0] p0_write_data, p1_write_data;
  logic [3:0]  p0_byte_enable, p1_byte_enable;
  logic        p0_read_req, p0_write_req;
  logic        p1_read_req, p1_write_req;
  logic        p0_ready, p1_ready;
  logic [31:0] p0_read_data, p1_read_data;
  logic        p0_read_data_valid, p1_read_data_valid;
  logic        bus_ready;
  logic [29:0] bus_addr;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_req, bus_write_req;
  logic [31:0] bus_read_data;
  logic        bus_read_data_valid;
  logic [2:0]  outstanding_count;
  logic        protocol_error;

  int n_pass = 0;
  int n_total = 0;

  system_bus_arbiter #(
    .MAX_OUTSTANDING(4),
    .FIXED_PRIORITY(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .p0_addr(p0_addr),
    .p0_write_data(p0_write_data),
    .p0_byte_enable(p0_byte_enable),
    .p0_read_req(p0_read_req),
    .p0_write_req(p0_write_req),
    .p0_ready(p0_ready),
    .p0_read_data(p0_read_data),
    .p0_read_data_valid(p0_read_data_valid),
    .p1_addr(p1_addr),
    .p1_write_data(p1_write_data),
    .p1_byte_enable(p1_byte_enable),
    .p1_read_req(p1_read_req),
    .p1_write_req(p1_write_req),
    .p1_ready(p1_ready),
    .p1_read_data(p1_read_data),
    .p1_read_data_valid(p1_read_data_valid),
    .bus_ready(bus_ready),
    .bus_addr(bus_addr),
    .bus_write_data(bus_write_data),
    .bus_byte_enable(bus_byte_enable),
    .bus_read_req(bus_read_req),
    .bus_write_req(bus_write_req),
    .bus_read_data(bus_read_data),
    .bus_read_data_valid(bus_read_data_valid),
    .outstanding_count(outstanding_count),
    .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    p0_read_req = 0; p0_write_req = 0;
    p1_read_req = 0; p1_write_req = 0;
    bus_read_data_valid = 0;
    bus_read_data = '0;
  endtask

  // Drive a return word at the next negedge and check its routing.
  task automatic ret(input logic [31:0] d, input logic to_p1,
                     input string tag);
    @(negedge clk);
    idle();
    bus_read_data_valid = 1;
    bus_read_data = d;
    #1;
    chk({tag, "_p0v"}, 32'(p0_read_data_valid), 32'(!to_p1));
    chk({tag, "_p1v"}, 32'(p1_read_data_valid), 32'(to_p1));
    chk({tag, "_dat"}, to_p1 ? p1_read_data : p0_read_data, d);
  endtask

  initial begin
    logic [3:0] ref_grants;
    logic [31:0] words [4];
    reset_n = 0;
    bus_ready = 0;
    p0_addr = '0; p1_addr = '0;
    p0_write_data = '0; p1_write_data = '0;
    p0_byte_enable = '0; p1_byte_enable = '0;
    idle();
    #12;
    chk("rst_count", 32'(outstanding_count), 0);
    chk("rst_perr", 32'(protocol_error), 0);
    chk("rst_busrd", 32'(bus_read_req), 0);
    chk("rst_addr", 32'(bus_addr), 0);
    @(negedge clk);
    reset_n = 1;
    bus_ready = 1;

    // 1: single p0 read, return 3 cycles later
    @(negedge clk);
    p0_read_req = 1;
    p0_addr = 30'h100;
    #1;
    chk("t1_addr", 32'(bus_addr), 32'h100);
    chk("t1_rdreq", 32'(bus_read_req), 1);
    chk("t1_p0rdy", 32'(p0_ready), 1);
    chk("t1_p1rdy", 32'(p1_ready), 0);
    @(negedge clk);
    idle();
    chk("t1_cnt1", 32'(outstanding_count), 1);
    @(negedge clk);
    ret(32'hDEADBEEF, 1'b0, "t1_ret");
    @(negedge clk);
    idle();
    chk("t1_cnt0", 32'(outstanding_count), 0);

    // bus stall: no ready, no transfer, no grant-state update
    p0_read_req = 1; p0_addr = 30'h10;
    p1_read_req = 1; p1_addr = 30'h20;
    bus_ready = 0;
    #1;
    chk("stall_p0rdy", 32'(p0_ready), 0);
    chk("stall_p1rdy", 32'(p1_ready), 0);
    chk("stall_addr", 32'(bus_addr), 32'h20);
    @(negedge clk);
    chk("stall_cnt", 32'(outstanding_count), 0);

    // 2: round-robin conflict, grants p1,p0,p1,p0
    bus_ready = 1;
    ref_grants = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_p1rdy%0d", i), 32'(p1_ready), 32'(ref_grants[i]));
      chk($sformatf("t2_p0rdy%0d", i), 32'(p0_ready), 32'(!ref_grants[i]));
      @(negedge clk);
    end
    idle();
    chk("t2_cnt4", 32'(outstanding_count), 4);
    words[0] = 32'hA; words[1] = 32'hB;
    words[2] = 32'hC; words[3] = 32'hD;
    for (int i = 0; i < 4; i++)
      ret(words[i], ref_grants[i], $sformatf("t2_ret%0d", i));
    @(negedge clk);
    idle();
    chk("t2_cnt0", 32'(outstanding_count), 0);

    // 3: fill with p0 reads, then full-FIFO behaviour
    p0_read_req = 1;
    p0_addr = 30'h200;
    repeat (4) @(negedge clk);
    chk("t3_cnt4", 32'(outstanding_count), 4);
    p1_write_req = 1;
    p1_addr = 30'h300;
    #1;
    chk("t3_p1rdy", 32'(p1_ready), 1);
    chk("t3_p0rdy", 32'(p0_ready), 0);
    chk("t3_wrreq", 32'(bus_write_req), 1);
    chk("t3_rdreq", 32'(bus_read_req), 0);
    @(negedge clk);
    p1_write_req = 0;
    #1;
    chk("t3_full_p0rdy", 32'(p0_ready), 0);
    bus_read_data_valid = 1;
    bus_read_data = 32'h55;
    #1;
    chk("t3_byp_p0rdy", 32'(p0_ready), 1);
    chk("t3_byp_p0v", 32'(p0_read_data_valid), 1);
    @(negedge clk);
    idle();
    chk("t3_cnt_still4", 32'(outstanding_count), 4);
    for (int i = 0; i < 4; i++)
      ret(32'h60 + 32'(i), 1'b0, $sformatf("t3_ret%0d", i));
    @(negedge clk);
    idle();
    chk("t3_cnt0", 32'(outstanding_count), 0);

    // 4: ten p1 writes
    p1_write_req = 1;
    p1_byte_enable = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      p1_addr = 30'(i + 'h40);
      p1_write_data = 32'h1000 + 32'(i);
      #1;
      chk($sformatf("t4_wr%0d", i), 32'(bus_write_req), 1);
      chk($sformatf("t4_be%0d", i), 32'(bus_byte_enable), 32'h3);
      chk($sformatf("t4_wd%0d", i), bus_write_data, 32'h1000 + 32'(i));
      chk($sformatf("t4_p1v%0d", i), 32'(p1_read_data_valid), 0);
      @(negedge clk);
    end
    idle();
    chk("t4_cnt0", 32'(outstanding_count), 0);

    // 5: return with empty FIFO
    bus_read_data_valid = 1;
    bus_read_data = 32'h77;
    #1;
    chk("t5_p0v", 32'(p0_read_data_valid), 0);
    chk("t5_p1v", 32'(p1_read_data_valid), 0);
    chk("t5_perr_pre", 32'(protocol_error), 0);
    @(posedge clk);
    #1;
    chk("t5_perr", 32'(protocol_error), 1);
    chk("t5_cnt0", 32'(outstanding_count), 0);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("t5_sticky", 32'(protocol_error), 1);

    // 6: async reset with two reads in flight
    p0_read_req = 1;
    @(negedge clk);
    p0_read_req = 0;
    p1_read_req = 1;
    @(negedge clk);
    idle();
    chk("t6_cnt2", 32'(outstanding_count), 2);
    #2;
    reset_n = 0;
    #1;
    chk("t6_rst_cnt", 32'(outstanding_count), 0);
    chk("t6_rst_perr", 32'(protocol_error), 0);
    @(negedge clk);
    reset_n = 1;
    p0_read_req = 1;
    p1_read_req = 1;
    #1;
    chk("t6_p1rdy", 32'(p1_ready), 1);
    chk("t6_p0rdy", 32'(p0_ready), 0);
    @(negedge clk);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
